// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: two-stage lookup/response pipeline
// with a blocking line refill and replay of the missing lookup.
module icache #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        icache_flush_i,
  input  logic [29:0] icache_req_addr_i,
  input  logic        icache_req_valid_i,
  output logic        icache_req_ready_o,
  output logic [29:0] icache_resp_addr_o,
  output logic [31:0] icache_resp_data_o,
  output logic        icache_resp_valid_o,
  input  logic        icache_resp_ready_i,
  output logic [29:0] mem_req_addr_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_resp_valid_i
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int RAM_W = IDX_W + OFF_W;

  typedef enum logic [1:0] {
    ST_LOOKUP  = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESTART = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [29:0]        lookup_addr_q, lookup_addr_d;
  logic               lookup_valid_q, lookup_valid_d;
  logic               resp_valid_q, resp_valid_d;
  logic [29:0]        resp_addr_q, resp_addr_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               mreq_valid_q, mreq_valid_d;
  logic [29:0]        mreq_addr_q, mreq_addr_d;
  logic [OFF_W-1:0]   rcnt_q, rcnt_d;
  logic               flushed_q, flushed_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [31:0]        data_mem [LINES*WORDS];
  logic [31:0]        rd_data_q;

  logic [IDX_W-1:0]   lk_idx_s, rf_idx_s;
  logic [TAG_W-1:0]   lk_tag_s, rf_tag_s;
  logic               hit_s, slot_free_s, req_ready_s, req_acc_s, miss_s;
  logic               refill_wr_s, refill_last_s, mreq_last_s;
  logic [RAM_W-1:0]   rd_addr_s;

  assign lk_idx_s = lookup_addr_q[OFF_W +: IDX_W];
  assign lk_tag_s = lookup_addr_q[29 -: TAG_W];
  // The refill line is identified by the issue address; only its offset bits advance.
  assign rf_idx_s = mreq_addr_q[OFF_W +: IDX_W];
  assign rf_tag_s = mreq_addr_q[29 -: TAG_W];

  assign hit_s       = (state_q == ST_LOOKUP) && lookup_valid_q && valid_q[lk_idx_s]
                       && (tag_mem[lk_idx_s] == lk_tag_s);
  assign slot_free_s = !resp_valid_q || icache_resp_ready_i;
  assign req_ready_s = (state_q == ST_LOOKUP) && (!lookup_valid_q || (hit_s && slot_free_s));
  assign req_acc_s   = req_ready_s && icache_req_valid_i;
  // A lookup that is being flushed is dropped instead of refilled.
  assign miss_s      = (state_q == ST_LOOKUP) && lookup_valid_q && !hit_s && !icache_flush_i;

  assign refill_wr_s   = (state_q == ST_REFILL) && mem_resp_valid_i;
  assign refill_last_s = refill_wr_s && (rcnt_q == {OFF_W{1'b1}});
  assign mreq_last_s   = (mreq_addr_q[OFF_W-1:0] == {OFF_W{1'b1}});

  assign rd_addr_s = req_acc_s ? icache_req_addr_i[RAM_W-1:0] : lookup_addr_q[RAM_W-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d        = state_q;
    lookup_addr_d  = lookup_addr_q;
    lookup_valid_d = lookup_valid_q;
    resp_valid_d   = resp_valid_q;
    resp_addr_d    = resp_addr_q;
    resp_data_d    = resp_data_q;
    mreq_valid_d   = mreq_valid_q;
    mreq_addr_d    = mreq_addr_q;
    rcnt_d         = rcnt_q;
    flushed_d      = flushed_q;
    valid_d        = valid_q;

    if (icache_resp_ready_i) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end

    case (state_q)
      ST_LOOKUP: begin
        if (hit_s && slot_free_s && !icache_flush_i) begin
          resp_valid_d = 1'b1;
          resp_addr_d  = lookup_addr_q;
          resp_data_d  = rd_data_q;
        end else begin
          resp_addr_d  = resp_addr_q;
        end
        if (req_acc_s) begin
          lookup_addr_d  = icache_req_addr_i;
          lookup_valid_d = 1'b1;
        end else if (hit_s && slot_free_s) begin
          lookup_valid_d = 1'b0;
        end else begin
          lookup_valid_d = lookup_valid_q;
        end
        if (miss_s) begin
          state_d           = ST_REFILL;
          valid_d[lk_idx_s] = 1'b0;
          mreq_valid_d      = 1'b1;
          mreq_addr_d       = {lookup_addr_q[29:OFF_W], {OFF_W{1'b0}}};
          rcnt_d            = {OFF_W{1'b0}};
          flushed_d         = 1'b0;
        end else begin
          state_d = ST_LOOKUP;
        end
      end
      ST_REFILL: begin
        if (mreq_valid_q && mem_req_ready_i) begin
          if (mreq_last_s) begin
            mreq_valid_d = 1'b0;
          end else begin
            mreq_addr_d = mreq_addr_q + 30'd1;
          end
        end else begin
          mreq_valid_d = mreq_valid_q;
        end
        if (refill_wr_s) begin
          rcnt_d = rcnt_q + OFF_W'(1);
        end else begin
          rcnt_d = rcnt_q;
        end
        if (icache_flush_i) begin
          flushed_d = 1'b1;
        end else begin
          flushed_d = flushed_q;
        end
        if (refill_last_s) begin
          valid_d[rf_idx_s] = 1'b1;
          state_d = (flushed_q || icache_flush_i) ? ST_LOOKUP : ST_RESTART;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_RESTART: begin
        state_d = ST_LOOKUP;
      end
      default: begin
        state_d = ST_LOOKUP;
      end
    endcase

    // A request accepted together with the flush is the jump target and survives.
    if (icache_flush_i) begin
      resp_valid_d = 1'b0;
      if (!req_acc_s) begin
        lookup_valid_d = 1'b0;
      end else begin
        lookup_valid_d = 1'b1;
      end
    end else begin
      flushed_d = flushed_d;
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_LOOKUP;
      lookup_addr_q  <= 30'd0;
      lookup_valid_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_addr_q    <= 30'd0;
      resp_data_q    <= 32'd0;
      mreq_valid_q   <= 1'b0;
      mreq_addr_q    <= 30'd0;
      rcnt_q         <= {OFF_W{1'b0}};
      flushed_q      <= 1'b0;
      valid_q        <= {LINES{1'b0}};
    end else begin
      state_q        <= state_d;
      lookup_addr_q  <= lookup_addr_d;
      lookup_valid_q <= lookup_valid_d;
      resp_valid_q   <= resp_valid_d;
      resp_addr_q    <= resp_addr_d;
      resp_data_q    <= resp_data_d;
      mreq_valid_q   <= mreq_valid_d;
      mreq_addr_q    <= mreq_addr_d;
      rcnt_q         <= rcnt_d;
      flushed_q      <= flushed_d;
      valid_q        <= valid_d;
    end
  end

  // Tag and data arrays; the data read is synchronous and read-before-write.
  always_ff @(posedge clk_i) begin
    if (refill_wr_s) begin
      data_mem[{rf_idx_s, rcnt_q}] <= mem_resp_data_i;
    end
    if (refill_last_s) begin
      tag_mem[rf_idx_s] <= rf_tag_s;
    end
    rd_data_q <= data_mem[rd_addr_s];
  end

  assign icache_req_ready_o  = req_ready_s;
  assign icache_resp_valid_o = resp_valid_q;
  assign icache_resp_addr_o  = resp_addr_q;
  assign icache_resp_data_o  = resp_data_q;
  assign mem_req_valid_o     = mreq_valid_q;
  assign mem_req_addr_o      = mreq_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a one-cycle-latency memory model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [29:0] req_addr;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] resp_addr;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [29:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_resp_data = 32'd0;
  logic        mem_resp_valid = 1'b0;

  always #5 clk = ~clk;

  icache #(.LINES(64), .WORDS(4)) dut (
    .clk_i(clk), .rst_i(rst), .icache_flush_i(flush),
    .icache_req_addr_i(req_addr), .icache_req_valid_i(req_valid), .icache_req_ready_o(req_ready),
    .icache_resp_addr_o(resp_addr), .icache_resp_data_o(resp_data),
    .icache_resp_valid_o(resp_valid), .icache_resp_ready_i(resp_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_resp_data_i(mem_resp_data), .mem_resp_valid_i(mem_resp_valid)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_0F00;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  logic [29:0] macc_addr[$];
  int          macc_cyc[$];
  int          racc_cyc[$];
  logic [29:0] rsp_addr[$];
  logic [31:0] rsp_data[$];
  int          rsp_cyc[$];

  // Handshake monitor and memory responder (data one cycle after acceptance).
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        macc_addr.push_back(mem_req_addr);
        macc_cyc.push_back(cyc);
      end
      if (req_valid && req_ready) racc_cyc.push_back(cyc);
      if (resp_valid && resp_ready) begin
        rsp_addr.push_back(resp_addr);
        rsp_data.push_back(resp_data);
        rsp_cyc.push_back(cyc);
      end
    end
    mem_resp_valid <= mem_req_valid && mem_req_ready && !rst;
    mem_resp_data  <= mem_word(mem_req_addr);
    cyc <= cyc + 1;
  end

  task automatic clear_logs();
    macc_addr.delete(); macc_cyc.delete(); racc_cyc.delete();
    rsp_addr.delete(); rsp_data.delete(); rsp_cyc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_req(input logic [29:0] a);
    int k;
    k = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && k < 100) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 100) check_eq("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_resp(input int n);
    int k;
    k = 0;
    while (rsp_addr.size() < n && k < 100) begin
      @(negedge clk); k++;
    end
    if (rsp_addr.size() < n) check_eq("resp_timeout", rsp_addr.size(), n);
  endtask

  task automatic access(input string tag, input logic [29:0] a, input int exp_mreq);
    clear_logs();
    send_req(a);
    req_valid = 1'b0;
    wait_resp(1);
    repeat (2) @(negedge clk);
    check_eq({tag, "_addr"}, rsp_addr[0], a);
    check_eq({tag, "_data"}, rsp_data[0], mem_word(a));
    check_eq({tag, "_mem_reqs"}, macc_addr.size(), exp_mreq);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; flush = 1'b0; req_addr = 30'd0; req_valid = 1'b0;
    resp_ready = 1'b1; mem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_resp_addr", resp_addr, 30'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_mem_valid", mem_req_valid, 1'b0);
    check_eq("rst_mem_addr", mem_req_addr, 30'd0);
    check_eq("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);

    // Cold miss on 0x100.
    clear_logs();
    send_req(30'h100);
    req_valid = 1'b0;
    wait_resp(1);
    repeat (3) @(negedge clk);
    check_eq("cold_mem_count", macc_addr.size(), 4);
    for (int i = 0; i < 4 && i < macc_addr.size(); i++) begin
      check_eq("cold_mem_addr", macc_addr[i], 30'h100 + 30'(i));
      check_eq("cold_mem_cycle", macc_cyc[i] - racc_cyc[0], 2 + i);
    end
    check_eq("cold_resp_addr", rsp_addr[0], 30'h100);
    check_eq("cold_resp_data", rsp_data[0], mem_word(30'h100));
    check_eq("cold_resp_latency", rsp_cyc[0] - racc_cyc[0], 9);

    // Streaming hits.
    clear_logs();
    send_req(30'h101);
    send_req(30'h102);
    send_req(30'h103);
    req_valid = 1'b0;
    wait_resp(3);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("stream_addr", rsp_addr[i], 30'h101 + 30'(i));
      check_eq("stream_data", rsp_data[i], mem_word(30'h101 + 30'(i)));
      check_eq("stream_cycle", rsp_cyc[i] - racc_cyc[0], 2 + i);
    end
    check_eq("stream_no_mem", macc_addr.size(), 0);

    // Response backpressure.
    clear_logs();
    resp_ready = 1'b0;
    send_req(30'h100);
    send_req(30'h101);
    req_valid = 1'b1;
    req_addr  = 30'h102;
    repeat (5) begin
      #1;
      check_eq("bp_resp_valid", resp_valid, 1'b1);
      check_eq("bp_resp_addr", resp_addr, 30'h100);
      check_eq("bp_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    send_req(30'h102);
    req_valid = 1'b0;
    wait_resp(3);
    repeat (5) @(negedge clk);
    check_eq("bp_resp_count", rsp_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_order_addr", rsp_addr[i], 30'h100 + 30'(i));
      check_eq("bp_order_data", rsp_data[i], mem_word(30'h100 + 30'(i)));
    end

    // Flush together with a new request while a response is pending.
    access("fill_104", 30'h104, 4);
    clear_logs();
    resp_ready = 1'b0;
    send_req(30'h104);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("fl_pending_valid", resp_valid, 1'b1);
    check_eq("fl_pending_addr", resp_addr, 30'h104);
    check_eq("fl_req_ready", req_ready, 1'b1);
    flush = 1'b1; req_valid = 1'b1; req_addr = 30'h200;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check_eq("fl_resp_cleared", resp_valid, 1'b0);
    resp_ready = 1'b1;
    wait_resp(1);
    repeat (3) @(negedge clk);
    check_eq("fl_resp_count", rsp_addr.size(), 1);
    check_eq("fl_next_addr", rsp_addr[0], 30'h200);
    check_eq("fl_next_data", rsp_data[0], mem_word(30'h200));

    // Flush in the middle of a refill.
    clear_logs();
    send_req(30'h2A8);
    req_valid = 1'b0;
    k = 0;
    while (macc_addr.size() < 2 && k < 50) begin
      @(negedge clk); k++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rf_mem_count", macc_addr.size(), 4);
    for (int i = 0; i < 4 && i < macc_addr.size(); i++)
      check_eq("rf_mem_addr", macc_addr[i], 30'h2A8 + 30'(i));
    check_eq("rf_no_resp", rsp_addr.size(), 0);
    access("rf_rehit", 30'h2A9, 0);
    check_eq("rf_rehit_latency", rsp_cyc[0] - racc_cyc[0], 2);

    // Index conflict and eviction.
    access("cf_first", 30'h000, 4);
    access("cf_alias", 30'h100, 4);
    access("cf_again", 30'h000, 4);
    access("cf_other_line", 30'h104, 0);
    access("cf_other_line2", 30'h2AA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
